tile_ram_to_fifo: RTL

TILE_RAM_TO_FIFO -- requirements
Module: tile_ram_to_fifo

---
 rtl/conv_pkg.sv | 23 ++
 rtl/tile_ram_to_fifo_if.sv | 31 +++
 rtl/tile_addr_gen.sv | 116 +++++++++++
 rtl/tile_ram_to_fifo.sv | 125 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared FSM encoding and read-latency bounds for the tile RAM-to-FIFO loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Keeps the valid-pipe width legal even if an out-of-range latency is configured.
    function automatic int clamp_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/tile_ram_to_fifo_if.sv
// RAM read port plus FIFO write port of the tile loader, bundled as one bus.
// Latency: n/a (wires only).
// Backpressure: fifo_almost_full from the FIFO side throttles address issue.
interface tile_ram_to_fifo_if #(
    parameter int DW = 32,
    parameter int AW = 16
);
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] data_from_ram;
    logic          fifo_push;
    logic [DW-1:0] data_to_fifo;
    logic          fifo_almost_full;

    // Loader side.
    modport master (
        output ram_addr,
        output fifo_push,
        output data_to_fifo,
        input  data_from_ram,
        input  fifo_almost_full
    );

    // RAM / FIFO side.
    modport slave (
        input  ram_addr,
        input  fifo_push,
        input  data_to_fifo,
        output data_from_ram,
        output fifo_almost_full
    );
endinterface

// File: rtl/tile_addr_gen.sv
// Nested channel/row/column counter producing tile element addresses with adders only.
// Latency: addr is a register; it advances on the edge after each accepted step.
// Backpressure: stall holds counters and address; addr_valid drops while stalled.
module tile_addr_gen #(
    parameter int AW = 16,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] ch_stride,
    input  logic [AW-1:0] row_stride,
    input  logic [LW-1:0] tile_ch,
    input  logic [LW-1:0] tile_row,
    input  logic [LW-1:0] tile_col,
    input  logic          step_req,
    input  logic          stall,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    output logic          last
);

    logic [LW-1:0] c_q, c_d, r_q, r_d, k_q, k_d;
    logic [LW-1:0] nc_q, nc_d, nr_q, nr_d, nk_q, nk_d;
    logic [AW-1:0] cs_q, cs_d, rs_q, rs_d;
    logic [AW-1:0] ch_base_q, ch_base_d;    // address of (c, 0, 0)
    logic [AW-1:0] row_base_q, row_base_d;  // address of (c, r, 0)
    logic [AW-1:0] addr_q, addr_d;
    logic          k_end, r_end, c_end;
    logic [AW-1:0] next_row, next_ch;

    assign k_end      = (k_q == nk_q - LW'(1));
    assign r_end      = (r_q == nr_q - LW'(1));
    assign c_end      = (c_q == nc_q - LW'(1));
    assign last       = k_end && r_end && c_end;
    assign addr_valid = step_req && !stall;
    assign addr       = addr_q;
    assign next_row   = row_base_q + rs_q;
    assign next_ch    = ch_base_q + cs_q;

    // Counter advance: column innermost, then row, then channel; holds after the last element.
    always_comb begin
        c_d        = c_q;
        r_d        = r_q;
        k_d        = k_q;
        nc_d       = nc_q;
        nr_d       = nr_q;
        nk_d       = nk_q;
        cs_d       = cs_q;
        rs_d       = rs_q;
        ch_base_d  = ch_base_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load) begin
            c_d        = '0;
            r_d        = '0;
            k_d        = '0;
            nc_d       = tile_ch;
            nr_d       = tile_row;
            nk_d       = tile_col;
            cs_d       = ch_stride;
            rs_d       = row_stride;
            ch_base_d  = base_addr;
            row_base_d = base_addr;
            addr_d     = base_addr;
        end else if (addr_valid && !last) begin
            if (!k_end) begin
                k_d    = k_q + LW'(1);
                addr_d = addr_q + AW'(1);
            end else if (!r_end) begin
                k_d        = '0;
                r_d        = r_q + LW'(1);
                row_base_d = next_row;
                addr_d     = next_row;
            end else begin
                k_d        = '0;
                r_d        = '0;
                c_d        = c_q + LW'(1);
                ch_base_d  = next_ch;
                row_base_d = next_ch;
                addr_d     = next_ch;
            end
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            nc_q       <= '0;
            nr_q       <= '0;
            nk_q       <= '0;
            cs_q       <= '0;
            rs_q       <= '0;
            ch_base_q  <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            c_q        <= c_d;
            r_q        <= r_d;
            k_q        <= k_d;
            nc_q       <= nc_d;
            nr_q       <= nr_d;
            nk_q       <= nk_d;
            cs_q       <= cs_d;
            rs_q       <= rs_d;
            ch_base_q  <= ch_base_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: rtl/tile_ram_to_fifo.sv
// Streams a 3-D tile (channel, row, column) from a RAM into a FIFO.
// Latency: first address one cycle after start; each push RD_LAT cycles after its address.
// Backpressure: fifo_almost_full stalls address issue; in-flight reads always land.
module tile_ram_to_fifo
    import conv_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 16,
    parameter int LW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] ch_stride,
    input  logic [AW-1:0] row_stride,
    input  logic [LW-1:0] tile_ch,
    input  logic [LW-1:0] tile_row,
    input  logic [LW-1:0] tile_col,
    output logic          busy,
    output logic          done,
    tile_ram_to_fifo_if.master bus
);

    localparam int LAT = clamp_lat(RD_LAT);

    state_e         state_q, state_d;
    logic           zero_q, zero_d;     // some tile dimension was zero at start
    logic [LAT-1:0] vld_q, vld_d;       // one bit per read in flight
    logic           load;
    logic           step_req;
    logic           addr_valid;
    logic           last;
    logic [AW-1:0]  gen_addr;
    logic [DW-1:0]  push_dat;

    // Every load passes through ISSUE for one cycle at least, so an empty tile
    // still reports done two cycles after start without touching the RAM.
    assign load     = (state_q == IDLE) && start;
    assign step_req = (state_q == ISSUE) && !zero_q && !abort;

    tile_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .base_addr  (base_addr),
        .ch_stride  (ch_stride),
        .row_stride (row_stride),
        .tile_ch    (tile_ch),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .step_req   (step_req),
        .stall      (bus.fifo_almost_full),
        .addr       (gen_addr),
        .addr_valid (addr_valid),
        .last       (last)
    );

    // Next-state and status decode; start outside IDLE (including the done cycle) is ignored.
    always_comb begin
        state_d = state_q;
        zero_d  = zero_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    zero_d  = (tile_ch == '0) || (tile_row == '0) || (tile_col == '0);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (zero_q) begin
                    state_d = FINISH;
                end else if (abort) begin
                    state_d = DRAIN;
                end else if (addr_valid && last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (vld_q == '0) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-tracking pipe: a bit enters on issue and leaves as the push strobe.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = addr_valid;
    end

    // State, empty-tile flag and valid pipe registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            zero_q  <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
        end
    end

    assign push_dat          = vld_q[LAT-1] ? bus.data_from_ram : '0;
    assign bus.fifo_push     = vld_q[LAT-1];
    assign bus.data_to_fifo  = push_dat;
    assign bus.ram_addr      = gen_addr;

endmodule
